// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect slice: machine word width,
// default reset PC and queue depth, the queue entry layout, and a word
// alignment helper used on redirect targets.
package fetch_redirect_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int DEFAULT_IFQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Bus bundle between the fetch unit and its environment.
//   imem_*  : 1-cycle-latency instruction memory read port
//   dec_*   : decode-stage jump/branch redirect
//   ex_*    : execute-stage mispredict flush and correct PC
//   dq_*    : instruction queue head handshake toward decode
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_redirect_unit_if;
  import fetch_redirect_unit_pkg::*;

  logic            imem_rd_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            dec_jump;
  logic [XLEN-1:0] dec_target;
  logic            ex_flush;
  logic [XLEN-1:0] ex_target;
  logic            dq_valid;
  logic            dq_ready;
  logic [XLEN-1:0] dq_instr;
  logic [XLEN-1:0] dq_pc;

  modport master (
    output imem_rd_en, imem_addr, dq_valid, dq_instr, dq_pc,
    input  imem_rdata, dec_jump, dec_target, ex_flush, ex_target, dq_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, dq_valid, dq_instr, dq_pc,
    output imem_rdata, dec_jump, dec_target, ex_flush, ex_target, dq_ready
  );

endinterface

// File: rtl/fetch_redirect_unit_ifq_fifo.sv
// Instruction queue: synchronous FIFO of ifq_entry_t.
//   flush     : drops all entries; same-cycle push/pop are ignored
//   push/pop  : enqueue push_data / retire the head
//   count     : current occupancy (0..DEPTH)
//   head      : entry at the read pointer (meaningful when count > 0)
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH is a power of two.
module ifq_fifo
  import fetch_redirect_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  ifq_entry_t               push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output ifq_entry_t               head
);

  localparam int PTR_W = $clog2(DEPTH);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues sequential reads to a
// 1-cycle-latency instruction memory under a credit check so the queue can
// never overflow, and redirects on decode jumps or execute flushes
// (execute has priority). Static not-taken prediction.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_redirect_unit_if.master (imem, redirect, decode queue)
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              IFQ_DEPTH = DEFAULT_IFQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_redirect_unit_if.master bus
);

  localparam int CNT_W = $clog2(IFQ_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(IFQ_DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  addr_p1;
  logic             inflight;
  logic             kill;
  logic [CNT_W-1:0] count;
  logic             redirect;
  logic [XLEN-1:0]  redirect_target;
  logic             enq;
  logic             deq;
  logic             issue;
  logic [CNT_W:0]   credit_use;
  ifq_entry_t       head;
  ifq_entry_t       enq_entry;

  // Stage p0: redirect priority, credit check and fetch issue.
  always_comb begin
    redirect        = bus.ex_flush | bus.dec_jump;
    redirect_target = bus.ex_flush ? bus.ex_target : bus.dec_target;
    enq             = inflight & ~kill & ~redirect;
    deq             = (count != '0) & bus.dq_ready & ~redirect;
    // Dequeues are deliberately not credited: the check stays conservative
    // and still sustains one instruction per cycle.
    credit_use      = {1'b0, count}
                    + {{CNT_W{1'b0}}, inflight}
                    + {{CNT_W{1'b0}}, enq};
    // rst_n gates issue so nothing is requested while reset is held.
    issue           = rst_n & ~redirect & (credit_use < DEPTH_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect & inflight;
      if (redirect)   fetch_pc <= word_align(redirect_target);
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Stage p1: the issued address travels with the returning word.
  always_ff @(posedge clk) begin
    if (issue) addr_p1 <= fetch_pc;
  end

  assign enq_entry = '{pc: addr_p1, instr: bus.imem_rdata};

  ifq_fifo #(.DEPTH(IFQ_DEPTH)) u_ifq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (deq),
    .count     (count),
    .head      (head)
  );

  // Stage p2: queue head toward decode, zeroed when empty.
  always_comb begin
    bus.imem_rd_en = issue;
    bus.imem_addr  = rst_n ? fetch_pc : '0;
    bus.dq_valid   = (count != '0);
    bus.dq_instr   = bus.dq_valid ? head.instr : '0;
    bus.dq_pc      = bus.dq_valid ? head.pc    : '0;
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit. The memory model returns the
// requested address as the instruction word, so dq_instr must equal dq_pc.
module tb_fetch_redirect_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_redirect_unit_if bus();

  fetch_redirect_unit #(
    .RESET_PC  (32'h0000_0000),
    .IFQ_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.dq_ready   = 1'b1;
    bus.dec_jump   = 1'b0;
    bus.dec_target = '0;
    bus.ex_flush   = 1'b0;
    bus.ex_target  = '0;
    bus.imem_rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
    check("rst_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_dq_instr", bus.dq_instr, 32'h0);
    check("rst_dq_pc", bus.dq_pc, 32'h0);

    // Release: cycle 0 fetch, dq_valid in cycle 2, then one per cycle
    rst_n = 1'b1;
    #1;
    check("c0_rd_en", {31'b0, bus.imem_rd_en}, 32'd1);
    check("c0_addr", bus.imem_addr, 32'h0);
    check("c0_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    next_cycle();
    check("c1_addr", bus.imem_addr, 32'h4);
    check("c1_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    next_cycle();
    check("c2_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    check("c2_dq_pc", bus.dq_pc, 32'h0);
    check("c2_dq_instr", bus.dq_instr, 32'h0);
    next_cycle();
    check("c3_dq_pc", bus.dq_pc, 32'h4);
    check("c3_dq_instr", bus.dq_instr, 32'h4);
    next_cycle();
    check("c4_dq_pc", bus.dq_pc, 32'h8);

    // Decode jump in cycle 5 to 0x100
    next_cycle();
    bus.dec_jump   = 1'b1;
    bus.dec_target = 32'h100;
    #1;
    check("j5_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
    check("j5_dq_pc", bus.dq_pc, 32'hC);
    next_cycle();
    bus.dec_jump = 1'b0;
    #1;
    check("j6_rd_en", {31'b0, bus.imem_rd_en}, 32'd1);
    check("j6_addr", bus.imem_addr, 32'h100);
    check("j6_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    next_cycle();
    check("j7_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    check("j7_addr", bus.imem_addr, 32'h104);
    next_cycle();
    check("j8_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    check("j8_dq_pc", bus.dq_pc, 32'h100);
    check("j8_dq_instr", bus.dq_instr, 32'h100);
    next_cycle();
    check("j9_dq_pc", bus.dq_pc, 32'h104);

    // Flush and jump together: execute target wins
    next_cycle();
    bus.ex_flush   = 1'b1;
    bus.ex_target  = 32'h200;
    bus.dec_jump   = 1'b1;
    bus.dec_target = 32'h300;
    #1;
    check("pri_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
    next_cycle();
    bus.ex_flush = 1'b0;
    bus.dec_jump = 1'b0;
    #1;
    check("pri_addr", bus.imem_addr, 32'h200);
    next_cycle();
    next_cycle();
    check("pri_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    check("pri_dq_pc", bus.dq_pc, 32'h200);

    // Unaligned target near the top of the address space wraps to 0
    next_cycle();
    bus.ex_flush  = 1'b1;
    bus.ex_target = 32'hFFFF_FFFE;
    next_cycle();
    bus.ex_flush = 1'b0;
    #1;
    check("wrap_rd_en", {31'b0, bus.imem_rd_en}, 32'd1);
    check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    check("wrap_addr1", bus.imem_addr, 32'h0);
    next_cycle();
    check("wrap_dq_pc0", bus.dq_pc, 32'hFFFF_FFFC);
    check("wrap_dq_instr0", bus.dq_instr, 32'hFFFF_FFFC);
    next_cycle();
    check("wrap_dq_pc1", bus.dq_pc, 32'h0);

    // Backpressure: redirect to 0 with decode stalled for 10 cycles
    next_cycle();
    bus.ex_flush  = 1'b1;
    bus.ex_target = 32'h0;
    bus.dq_ready  = 1'b0;
    next_cycle();
    bus.ex_flush = 1'b0;
    repeat (10) next_cycle();
    check("bp_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
    check("bp_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    check("bp_dq_pc", bus.dq_pc, 32'h0);
    bus.dq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_drain_valid", {31'b0, bus.dq_valid}, 32'd1);
      check("bp_drain_pc", bus.dq_pc, 32'(i * 4));
      check("bp_drain_instr", bus.dq_instr, 32'(i * 4));
      next_cycle();
    end

    // Reset pulse while the queue is full
    bus.dq_ready = 1'b0;
    repeat (8) next_cycle();
    check("full_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    check("mid_rst_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
    check("mid_rst_dq_pc", bus.dq_pc, 32'h0);
    check("mid_rst_addr", bus.imem_addr, 32'h0);
    next_cycle();
    rst_n        = 1'b1;
    bus.dq_ready = 1'b1;
    #1;
    check("rel_rd_en", {31'b0, bus.imem_rd_en}, 32'd1);
    check("rel_addr", bus.imem_addr, 32'h0);
    next_cycle();
    check("rel_c1_dq_valid", {31'b0, bus.dq_valid}, 32'd0);
    next_cycle();
    check("rel_c2_dq_valid", {31'b0, bus.dq_valid}, 32'd1);
    check("rel_c2_dq_pc", bus.dq_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
